mcp3_arb_rr_hold: RTL and testbench
===================================

Name: mcp3_arb_rr_hold

Overview:
- Parametrised round-robin arbiter for NUM_REQ requesters, with a registered encoded winner. Successor to the fixed 16-way arbiter in the AFP command/response path.
- Adds a high-priority request class and an optional sticky-grant mode. In sticky mode the winner is kept across consecutive takes, bounded by MAX_HOLD.
- Sits between per-source request latches and a single downstream consumer. The consumer pulses req_taken, and req_clear tells the source latches which request to drop.

Parameters:
- NUM_REQ, 16, number of requesters; legal range 2..64.
- ENC_W, $clog2(NUM_REQ), width of the encoded winner; derived, not overridden.
- STICKY, 0, 1 = the winner may be re-granted after a take while it is still requesting.
- MAX_HOLD, 4, maximum consecutive takes per winner when STICKY=1; legal range 1..255.

Ports:
- clock  in  1  Single clock; all state updates on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- req_taken  in  1  Consumer accepted the current winner this cycle. Meaningful only when winner_valid=1; ignored otherwise.
- req_bus  in  NUM_REQ  Active requests, one bit per source.
- req_hipri  in  NUM_REQ  High-priority qualifier; a bit is effective only where the matching req_bus bit is also set.
- winner_valid  out  1  winner holds a valid grant.
- winner  out  ENC_W  Encoded index of the granted requester.
- req_clear  out  NUM_REQ  One-hot clear of the granted request (combinational).
- hold_cnt  out  8  Consecutive takes by the current winner (debug/perf).

Behaviour:
- Reset: winner=0, winner_valid=0, hold_cnt=0, last-winner pointer=0. req_clear=0 whenever reset=1 or winner_valid=0.
- Registered state: winner_q, winner_valid_q, hold_cnt_q, and the pointer. The pointer is winner_q, and it is kept even when winner_valid_q=0.
- Outputs winner and winner_valid come directly from flops.
- req_clear = onehot(winner_q) when req_taken & winner_valid_q, else 0. Zero latency, same cycle as req_taken.
- cur = onehot(winner_q) when winner_valid_q=1, else all-zero.
- Candidate search: circular scan starting at index winner_q+1, wrapping from NUM_REQ-1 to 0. The first hit wins.
  - Candidates are req_hipri & req_bus & ~cur if that set is nonzero.
  - Otherwise candidates are req_bus & ~cur.
  - new_valid = (candidate set nonzero).
  - When winner_valid_q=0, cur=0, so index winner_q itself is eligible, last in scan order.
- pick_new is asserted when any of the following holds:
  - winner_valid_q=0;
  - req_bus[winner_q]=0 (request dropped);
  - req_taken=1 and not retain.
- retain = STICKY & req_taken & winner_valid_q & req_bus[winner_q] & (hold_cnt_q < MAX_HOLD-1) & no effective hipri request from any other index.
- Next-state rules:
  - If pick_new: winner_d = new winner index, winner_valid_d = new_valid. If new_valid=0, winner_q holds its old value.
  - Otherwise winner is unchanged and winner_valid_d=1.
- hold_cnt rules:
  - Cleared to 0 on any change of winner or when winner_valid_d=0.
  - Incremented on retain; saturates at 255.
- Sole requester that is taken, STICKY=0: winner_valid drops for one cycle (that requester is excluded as cur), then it is re-granted the following cycle. This single-cycle bubble is required behaviour.
- A winner dropping its request while req_taken=1 is treated as a take; req_clear still fires.
- Grant latency: a request appearing at cycle t with winner_valid_q=0 gives winner_valid=1 at t+1.
- Reset asserted mid-grant: all state returns to reset values at the next edge. req_clear is 0 while reset=1, whatever req_taken is.
- Arithmetic: the wrap uses a modulo-NUM_REQ index, which must work for non-power-of-2 NUM_REQ. Indices ≥ NUM_REQ never appear on winner.
- Implementation is free in structure (parallel prefix or loop scan). The combinational path from req_bus to winner_d must be free of latches and loops.

Test Plan:
- Reset then req_bus=16'h0000 for 5 cycles → winner_valid=0, winner=0, req_clear=0 throughout.
- NUM_REQ=16, STICKY=0, req_bus=16'h8421 held, req_taken pulsed every cycle the grant is valid → grants cycle 0,5,10,15,0,…; req_clear=16'h0001,16'h0020,… in the same cycle as each take.
- req_bus=16'hFFFF with winner=3, then req_hipri=16'h0100 and a take → next winner=8; drop req_hipri and take → winner=9.
- STICKY=1, MAX_HOLD=3, req_bus=16'h0012, winner=1, take every cycle → winner stays 1 for 3 takes with hold_cnt 0,1,2; next winner=4 with hold_cnt=0.
- Only req_bus[7]=1, take at t → winner_valid=0 at t+1, winner_valid=1 with winner=7 at t+2.
- NUM_REQ=5, req_bus=5'b10001, winner=4, take → winner=0, no out-of-range index. Assert reset during a grant → winner_valid=0 and hold_cnt=0 next cycle.

Source files
------------

// File: rtl/mcp3_arb_rr_hold.sv
// Round-robin arbiter with a high-priority request class and an optional
// sticky grant bounded by MAX_HOLD consecutive takes. The encoded winner is registered.
module mcp3_arb_rr_hold #(
    parameter int NUM_REQ  = 16,
    parameter int ENC_W    = $clog2(NUM_REQ),
    parameter bit STICKY   = 1'b0,
    parameter int MAX_HOLD = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_taken,
    input  logic [NUM_REQ-1:0] req_bus,
    input  logic [NUM_REQ-1:0] req_hipri,
    output logic               winner_valid,
    output logic [ENC_W-1:0]   winner,
    output logic [NUM_REQ-1:0] req_clear,
    output logic [7:0]         hold_cnt
);

    localparam int              SUM_W    = ENC_W + 1;
    localparam logic [SUM_W-1:0] NUM_SUM = SUM_W'(NUM_REQ);
    localparam logic [7:0]      HOLD_LIM = 8'(MAX_HOLD - 1);

    logic [ENC_W-1:0]   winner_reg, winner_next;
    logic               valid_reg, valid_next;
    logic [7:0]         hold_reg, hold_next;

    logic [NUM_REQ-1:0] win_onehot;
    logic [NUM_REQ-1:0] cur;
    logic [NUM_REQ-1:0] eff_hi;
    logic [NUM_REQ-1:0] hi_cand;
    logic [NUM_REQ-1:0] lo_cand;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] scan_hit;
    logic [ENC_W-1:0]   scan_idx [NUM_REQ];

    logic               new_valid;
    logic [ENC_W-1:0]   new_idx;
    logic               win_req;
    logic               other_hi;
    logic               retain;
    logic               pick_new;

    // Slot gi of the scan holds index (winner_reg + gi + 1) mod NUM_REQ; a single
    // conditional subtract suffices because the sum is always below 2*NUM_REQ.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_scan
        logic [SUM_W-1:0] sum;
        assign win_onehot[gi] = (winner_reg == ENC_W'(gi));
        assign sum            = {1'b0, winner_reg} + SUM_W'(gi + 1);
        assign scan_idx[gi]   = (sum >= NUM_SUM) ? ENC_W'(sum - NUM_SUM) : ENC_W'(sum);
        assign scan_hit[gi]   = cand[scan_idx[gi]];
    end

    assign cur     = valid_reg ? win_onehot : '0;
    assign eff_hi  = req_hipri & req_bus;
    assign hi_cand = eff_hi & ~cur;
    assign lo_cand = req_bus & ~cur;
    assign cand    = (|hi_cand) ? hi_cand : lo_cand;

    assign new_valid = |cand;
    assign win_req   = |(req_bus & win_onehot);
    assign other_hi  = |(eff_hi & ~win_onehot);

    assign retain   = STICKY && req_taken && valid_reg && win_req &&
                      (hold_reg < HOLD_LIM) && !other_hi;
    assign pick_new = !valid_reg || !win_req || (req_taken && !retain);

    // Lowest scan offset wins: walk from the far end so nearer hits overwrite.
    always_comb begin
        new_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (scan_hit[k]) begin
                new_idx = scan_idx[k];
            end
        end
    end

    always_comb begin
        winner_next = winner_reg;
        valid_next  = 1'b1;
        hold_next   = hold_reg;
        if (pick_new) begin
            valid_next = new_valid;
            hold_next  = 8'd0;
            if (new_valid) begin
                winner_next = new_idx;
            end
        end else if (retain) begin
            hold_next = (hold_reg == 8'hFF) ? hold_reg : hold_reg + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            winner_reg <= '0;
            valid_reg  <= 1'b0;
            hold_reg   <= 8'd0;
        end else begin
            winner_reg <= winner_next;
            valid_reg  <= valid_next;
            hold_reg   <= hold_next;
        end
    end

    assign winner       = winner_reg;
    assign winner_valid = valid_reg;
    assign hold_cnt     = hold_reg;
    assign req_clear    = (req_taken && valid_reg && !reset) ? win_onehot : '0;

endmodule

// File: tb/tb_mcp3_arb_rr_hold.sv
// Bench for mcp3_arb_rr_hold: three configurations (16-way, 16-way sticky, 5-way)
// run side by side under directed steps, then randomized traffic against a reference model.
module tb_mcp3_arb_rr_hold;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] req_v  [3];
    logic [63:0] hip_v  [3];
    logic        take_v [3];

    logic        v0, v1, v2;
    logic [3:0]  w0, w1;
    logic [2:0]  w2;
    logic [15:0] c0, c1;
    logic [4:0]  c2;
    logic [7:0]  h0, h1, h2;

    mcp3_arb_rr_hold #(.NUM_REQ(16), .STICKY(1'b0), .MAX_HOLD(4)) u_d0 (
        .clock(clk), .reset(rst), .req_taken(take_v[0]),
        .req_bus(req_v[0][15:0]), .req_hipri(hip_v[0][15:0]),
        .winner_valid(v0), .winner(w0), .req_clear(c0), .hold_cnt(h0)
    );

    mcp3_arb_rr_hold #(.NUM_REQ(16), .STICKY(1'b1), .MAX_HOLD(3)) u_d1 (
        .clock(clk), .reset(rst), .req_taken(take_v[1]),
        .req_bus(req_v[1][15:0]), .req_hipri(hip_v[1][15:0]),
        .winner_valid(v1), .winner(w1), .req_clear(c1), .hold_cnt(h1)
    );

    mcp3_arb_rr_hold #(.NUM_REQ(5), .STICKY(1'b0), .MAX_HOLD(4)) u_d2 (
        .clock(clk), .reset(rst), .req_taken(take_v[2]),
        .req_bus(req_v[2][4:0]), .req_hipri(hip_v[2][4:0]),
        .winner_valid(v2), .winner(w2), .req_clear(c2), .hold_cnt(h2)
    );

    typedef struct {
        int win;
        bit valid;
        int hold;
    } mstate_t;

    mstate_t ms [3];
    int n_cfg  [3] = '{16, 16, 5};
    bit st_cfg [3] = '{1'b0, 1'b1, 1'b0};
    int mh_cfg [3] = '{4, 3, 4};

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [63:0] obs_valid(int i);
        case (i)
            0:       return 64'(v0);
            1:       return 64'(v1);
            default: return 64'(v2);
        endcase
    endfunction

    function automatic logic [63:0] obs_win(int i);
        case (i)
            0:       return 64'(w0);
            1:       return 64'(w1);
            default: return 64'(w2);
        endcase
    endfunction

    function automatic logic [63:0] obs_clr(int i);
        case (i)
            0:       return 64'(c0);
            1:       return 64'(c1);
            default: return 64'(c2);
        endcase
    endfunction

    function automatic logic [63:0] obs_hold(int i);
        case (i)
            0:       return 64'(h0);
            1:       return 64'(h1);
            default: return 64'(h2);
        endcase
    endfunction

    // Reference: arbitration rules applied directly to integer state and bit sets.
    function automatic mstate_t model_next(mstate_t s, int n, bit sticky, int maxh,
                                           logic [63:0] rq_in, logic [63:0] hp_in,
                                           bit take, bit r);
        mstate_t     nx;
        logic [63:0] mask, rq, hi, pool;
        bit          other_hi, retain, pick, found;
        nx.win = 0; nx.valid = 0; nx.hold = 0;
        if (r) return nx;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        rq   = rq_in & mask;
        hi   = rq & hp_in;
        other_hi = 0;
        for (int j = 0; j < n; j++) begin
            if (j != s.win && hi[j]) other_hi = 1;
        end
        retain = sticky && take && s.valid && rq[s.win] && (s.hold + 1 < maxh) && !other_hi;
        pick   = !s.valid || !rq[s.win] || (take && !retain);
        if (!pick) begin
            nx.win   = s.win;
            nx.valid = 1;
            nx.hold  = retain ? ((s.hold >= 255) ? 255 : s.hold + 1) : s.hold;
        end else begin
            if (s.valid) begin
                hi[s.win] = 1'b0;
                rq[s.win] = 1'b0;
            end
            pool  = (hi != 0) ? hi : rq;
            nx.win = s.win;
            found = 0;
            for (int k = 1; k <= n; k++) begin
                int j;
                j = (s.win + k) % n;
                if (!found && pool[j]) begin
                    found  = 1;
                    nx.win = j;
                end
            end
            nx.valid = found;
            nx.hold  = 0;
        end
        return nx;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational clear, advance model, check registered outputs.
    task automatic step();
        logic [63:0] exp_clr;
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_clr = (!rst && take_v[i] && ms[i].valid) ? (64'd1 << ms[i].win) : 64'd0;
            check($sformatf("d%0d req_clear", i), obs_clr(i), exp_clr);
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            ms[i] = model_next(ms[i], n_cfg[i], st_cfg[i], mh_cfg[i],
                               req_v[i], hip_v[i], take_v[i], rst);
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("d%0d winner_valid", i), obs_valid(i), 64'(ms[i].valid));
            check($sformatf("d%0d winner", i),       obs_win(i),   64'(ms[i].win));
            check($sformatf("d%0d hold_cnt", i),     obs_hold(i),  64'(ms[i].hold));
        end
    endtask

    task automatic take_when_valid();
        for (int i = 0; i < 3; i++) take_v[i] = ms[i].valid;
    endtask

    initial begin
        int e0 [4] = '{5, 10, 15, 0};
        int e1 [4] = '{1, 1, 1, 4};
        int f1 [4] = '{0, 1, 2, 0};
        int e2 [4] = '{4, 0, 4, 0};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_v[i] = '0; hip_v[i] = '0; take_v[i] = 1'b0;
            ms[i].win = 0; ms[i].valid = 0; ms[i].hold = 0;
        end
        @(posedge clk);
        #1;
        step();
        step();

        // Idle after reset: nothing may be granted.
        rst = 1'b0;
        for (int c = 0; c < 5; c++) step();
        check("idle winner_valid", 64'(v0), 64'd0);

        // Round robin, sticky hold and non-power-of-2 wrap.
        req_v[0] = 64'h8421;
        req_v[1] = 64'h0012;
        req_v[2] = 64'h11;
        for (int s = 0; s < 4; s++) begin
            take_when_valid();
            step();
            check("d0 rr sequence", 64'(w0), 64'(e0[s]));
            check("d1 sticky winner", 64'(w1), 64'(e1[s]));
            check("d1 sticky hold", 64'(h1), 64'(f1[s]));
            check("d2 wrap winner", 64'(w2), 64'(e2[s]));
        end

        // High-priority override, then plain round robin resumes.
        req_v[0] = 64'hFFFF;
        req_v[1] = '0;
        req_v[2] = '0;
        for (int s = 0; s < 3; s++) begin
            take_when_valid();
            step();
        end
        check("d0 before hipri", 64'(w0), 64'd3);
        hip_v[0] = 64'h0100;
        take_when_valid();
        step();
        check("d0 hipri winner", 64'(w0), 64'd8);
        hip_v[0] = '0;
        take_when_valid();
        step();
        check("d0 after hipri", 64'(w0), 64'd9);

        // Sole requester taken: one-cycle bubble, then re-granted.
        req_v[0] = 64'h0080;
        take_v[0] = 1'b0;
        step();
        check("d0 sole grant", 64'(w0), 64'd7);
        take_v[0] = 1'b1;
        step();
        check("d0 bubble valid", 64'(v0), 64'd0);
        take_v[0] = 1'b0;
        step();
        check("d0 regrant valid", 64'(v0), 64'd1);
        check("d0 regrant winner", 64'(w0), 64'd7);

        // Reset in the middle of a sticky hold.
        req_v[1] = 64'h0012;
        for (int s = 0; s < 2; s++) begin
            take_when_valid();
            step();
        end
        check("d1 hold before reset", 64'(h1), 64'd1);
        rst = 1'b1;
        take_v[1] = 1'b1;
        step();
        check("d1 reset valid", 64'(v1), 64'd0);
        check("d1 reset hold", 64'(h1), 64'd0);
        rst = 1'b0;

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                case ($urandom_range(0, 3))
                    0:       req_v[i] = {$urandom, $urandom} & {$urandom, $urandom};
                    1:       req_v[i] = 64'd1 << $urandom_range(0, 15);
                    default: req_v[i] = {$urandom, $urandom};
                endcase
                hip_v[i]  = ($urandom_range(0, 2) == 0) ?
                            ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom}) : 64'd0;
                take_v[i] = ($urandom_range(0, 3) != 0);
            end
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
